// File: rtl/hazard_controller.sv
// Hazard controller for a five-stage pipeline.
// Tracks a shadow copy of the E/M/W destination registers to detect
// load-use hazards (stall + one bubble), branch flushes, and to select
// operand forwarding sources for the execute stage.
module hazard_controller #(
    parameter int REGWIDTH    = 4,
    parameter int OPCODEWIDTH = 4,
    parameter int CNTWIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [OPCODEWIDTH-1:0] opcodeD,
    input  logic [REGWIDTH-1:0]    rs1D,
    input  logic [REGWIDTH-1:0]    rs2D,
    input  logic [REGWIDTH-1:0]    rdD,
    input  logic                   writeEnableDD,
    input  logic                   resultSelectorWBD,
    input  logic                   branchTakenE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flushD,
    output logic                   flushE,
    output logic [1:0]             forwardAE,
    output logic [1:0]             forwardBE,
    output logic [CNTWIDTH-1:0]    stallCount
);

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [CNTWIDTH-1:0] CNT_ONE = {{(CNTWIDTH-1){1'b0}}, 1'b1};

    // Hazard detection is opcode-agnostic: the decoder already folds the
    // opcode into writeEnableDD / resultSelectorWBD.
    logic unused_opcode;
    assign unused_opcode = ^opcodeD;

    logic [REGWIDTH-1:0] rd_e_q, rd_e_d, rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d;
    logic                we_e_q, we_e_d, is_load_e_q, is_load_e_d;
    logic [REGWIDTH-1:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
    logic                we_m_q, we_m_d, we_w_q, we_w_d;
    logic [CNTWIDTH-1:0] stall_count_q, stall_count_d;

    logic lw_stall, stall_c, flush_e_c;
    logic [1:0] fwd_a_c, fwd_b_c;

    // Load-use detection and stall/flush arbitration; a taken branch wins.
    always_comb begin
        lw_stall  = is_load_e_q && ((rd_e_q == rs1D) || (rd_e_q == rs2D));
        stall_c   = lw_stall && !branchTakenE;
        flush_e_c = lw_stall || branchTakenE;
    end

    // Forwarding select from registered state only; memory stage beats writeback.
    always_comb begin
        fwd_a_c = FWD_REGFILE;
        fwd_b_c = FWD_REGFILE;
        if (we_m_q && (rd_m_q == rs1_e_q))      fwd_a_c = FWD_MEM;
        else if (we_w_q && (rd_w_q == rs1_e_q)) fwd_a_c = FWD_WB;
        if (we_m_q && (rd_m_q == rs2_e_q))      fwd_b_c = FWD_MEM;
        else if (we_w_q && (rd_w_q == rs2_e_q)) fwd_b_c = FWD_WB;
    end

    // Shadow pipeline advance; a flushed E slot becomes an all-zero bubble.
    always_comb begin
        rd_w_d = rd_m_q;
        we_w_d = we_m_q;
        rd_m_d = rd_e_q;
        we_m_d = we_e_q;
        if (flush_e_c) begin
            rd_e_d      = '0;
            rs1_e_d     = '0;
            rs2_e_d     = '0;
            we_e_d      = 1'b0;
            is_load_e_d = 1'b0;
        end else begin
            rd_e_d      = rdD;
            rs1_e_d     = rs1D;
            rs2_e_d     = rs2D;
            we_e_d      = writeEnableDD;
            is_load_e_d = writeEnableDD && resultSelectorWBD;
        end
    end

    // Saturating count of load-use stall cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != '1))
            stall_count_d = stall_count_q + CNT_ONE;
    end

    // State registers; reset drops every stage to a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_e_q        <= '0;
            rs1_e_q       <= '0;
            rs2_e_q       <= '0;
            we_e_q        <= 1'b0;
            is_load_e_q   <= 1'b0;
            rd_m_q        <= '0;
            we_m_q        <= 1'b0;
            rd_w_q        <= '0;
            we_w_q        <= 1'b0;
            stall_count_q <= '0;
        end else begin
            rd_e_q        <= rd_e_d;
            rs1_e_q       <= rs1_e_d;
            rs2_e_q       <= rs2_e_d;
            we_e_q        <= we_e_d;
            is_load_e_q   <= is_load_e_d;
            rd_m_q        <= rd_m_d;
            we_m_q        <= we_m_d;
            rd_w_q        <= rd_w_d;
            we_w_q        <= we_w_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Outputs are gated by reset so a live branchTakenE cannot leak a flush.
    always_comb begin
        stallF     = rst && stall_c;
        stallD     = rst && stall_c;
        flushD     = rst && branchTakenE;
        flushE     = rst && flush_e_c;
        forwardAE  = rst ? fwd_a_c : FWD_REGFILE;
        forwardBE  = rst ? fwd_b_c : FWD_REGFILE;
        stallCount = stall_count_q;
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each step pushes the expected
// outputs from a small reference pipeline, then pops and compares them.
module tb_hazard_controller;

    localparam int RW = 4;
    localparam int OW = 4;
    localparam int CW = 4;

    typedef struct packed {
        logic          sf, sd, fd, fe;
        logic [1:0]    fa, fb;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [OW-1:0] opcodeD;
    logic [RW-1:0] rs1D, rs2D, rdD;
    logic          writeEnableDD, resultSelectorWBD, branchTakenE;
    logic          stallF, stallD, flushD, flushE;
    logic [1:0]    forwardAE, forwardBE;
    logic [CW-1:0] stallCount;

    always #5 clk = ~clk;

    hazard_controller #(.REGWIDTH(RW), .OPCODEWIDTH(OW), .CNTWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .opcodeD(opcodeD), .rs1D(rs1D), .rs2D(rs2D),
        .rdD(rdD), .writeEnableDD(writeEnableDD),
        .resultSelectorWBD(resultSelectorWBD), .branchTakenE(branchTakenE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallCount(stallCount)
    );

    // reference pipeline state
    logic [RW-1:0] m_rd_e, m_rs1_e, m_rs2_e, m_rd_m, m_rd_w;
    logic          m_we_e, m_ld_e, m_we_m, m_we_w;
    logic [CW-1:0] m_cnt;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rd_e = '0; m_rs1_e = '0; m_rs2_e = '0; m_we_e = 1'b0; m_ld_e = 1'b0;
        m_rd_m = '0; m_we_m = 1'b0; m_rd_w = '0; m_we_w = 1'b0; m_cnt = '0;
    endtask

    function automatic logic [1:0] fwd(input logic [RW-1:0] rs);
        if (m_we_m && m_rd_m == rs) return 2'b10;
        if (m_we_w && m_rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic lw;
        lw    = m_ld_e && (m_rd_e == rs1D || m_rd_e == rs2D);
        e.sf  = lw && !branchTakenE;
        e.sd  = lw && !branchTakenE;
        e.fd  = branchTakenE;
        e.fe  = lw || branchTakenE;
        e.fa  = fwd(m_rs1_e);
        e.fb  = fwd(m_rs2_e);
        e.cnt = m_cnt;
        return e;
    endfunction

    task automatic model_clock(input logic [RW-1:0] rs1, rs2, rd, input logic we, sel, br);
        logic lw;
        lw = m_ld_e && (m_rd_e == rs1 || m_rd_e == rs2);
        if (lw && !br && m_cnt != '1) m_cnt = m_cnt + {{(CW-1){1'b0}}, 1'b1};
        m_rd_w = m_rd_m; m_we_w = m_we_m;
        m_rd_m = m_rd_e; m_we_m = m_we_e;
        if (lw || br) begin
            m_rd_e = '0; m_rs1_e = '0; m_rs2_e = '0; m_we_e = 1'b0; m_ld_e = 1'b0;
        end else begin
            m_rd_e = rd; m_rs1_e = rs1; m_rs2_e = rs2; m_we_e = we; m_ld_e = we && sel;
        end
    endtask

    // Called just after a rising edge: drive, compare before the next edge, clock.
    task automatic step(input logic [RW-1:0] rs1, rs2, rd, input logic we, sel, br);
        exp_t e, got;
        opcodeD = OW'($urandom_range(0, 15));
        rs1D = rs1; rs2D = rs2; rdD = rd;
        writeEnableDD = we; resultSelectorWBD = sel; branchTakenE = br;
        sb_q.push_back(model_out());
        #1;
        got = '{stallF, stallD, flushD, flushE, forwardAE, forwardBE, stallCount};
        e = sb_q.pop_front();
        check("ctrl", {24'd0, got.sf, got.sd, got.fd, got.fe, got.fa, got.fb},
                      {24'd0, e.sf, e.sd, e.fd, e.fe, e.fa, e.fb});
        check("cnt", {28'd0, got.cnt}, {28'd0, e.cnt});
        @(posedge clk);
        model_clock(rs1, rs2, rd, we, sel, br);
        #1;
    endtask

    initial begin
        rst = 1'b0; opcodeD = '0; rs1D = '0; rs2D = '0; rdD = '0;
        writeEnableDD = 1'b0; resultSelectorWBD = 1'b0; branchTakenE = 1'b0;
        model_reset();
        #12;
        check("reset_outs", {24'd0, stallF, stallD, flushD, flushE, forwardAE, forwardBE, stallCount}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // load rd=3 then dependent reader on rs1
        step(0, 0, 3, 1, 1, 0);
        step(3, 7, 4, 1, 0, 0);
        check("cnt_after_lw", {28'd0, stallCount}, 32'd1);
        step(3, 7, 4, 1, 0, 0);
        check("fa_lw_wb", {30'd0, forwardAE}, 32'h1);

        // ALU writer rd=5 -> immediate reader, then reader after a non-writer
        step(0, 0, 5, 1, 0, 0);
        step(9, 5, 6, 0, 0, 0);
        check("fb_mem", {30'd0, forwardBE}, 32'h2);
        step(0, 0, 5, 1, 0, 0);
        step(0, 0, 12, 0, 0, 0);
        step(9, 5, 6, 0, 0, 0);
        check("fb_wb", {30'd0, forwardBE}, 32'h1);

        // both M and W write rd=2: memory stage wins
        step(0, 0, 2, 1, 0, 0);
        step(0, 0, 2, 1, 0, 0);
        step(2, 9, 6, 0, 0, 0);
        check("fa_mem_prio", {30'd0, forwardAE}, 32'h2);

        // branch in the same cycle as a load-use hazard
        step(0, 0, 1, 1, 1, 0);
        step(1, 0, 6, 1, 0, 1);
        check("cnt_branch", {28'd0, stallCount}, 32'd1);

        // store is not a hazard source
        step(0, 0, 8, 0, 1, 0);
        step(8, 8, 6, 0, 0, 0);
        check("fa_store", {30'd0, forwardAE}, 32'h0);
        check("fb_store", {30'd0, forwardBE}, 32'h0);

        // drive the counter into saturation
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 10, 1, 1, 0);
            step(10, 1, 4, 1, 0, 0);
            step(10, 1, 4, 1, 0, 0);
        end
        check("cnt_sat", {28'd0, stallCount}, 32'hF);

        // reset asserted in the middle of a stall
        step(0, 0, 11, 1, 1, 0);
        rs1D = 11; rs2D = 0; rdD = 3; writeEnableDD = 1'b1; resultSelectorWBD = 1'b0;
        #1;
        check("pre_rst_stall", {31'd0, stallF}, 32'd1);
        branchTakenE = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_async", {24'd0, stallF, stallD, flushD, flushE, forwardAE, forwardBE, stallCount}, 32'd0);
        @(posedge clk); #1;
        check("rst_held", {24'd0, stallF, stallD, flushD, flushE, forwardAE, forwardBE, stallCount}, 32'd0);
        model_reset();
        rst = 1'b1;
        step(11, 0, 3, 1, 0, 0);
        check("cnt_after_rst", {28'd0, stallCount}, 32'd0);

        // random traffic on a small register range to provoke hazards
        for (int i = 0; i < 60; i++) begin
            step(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameters: REGWIDTH, default 4, register-address width; OPCODEWIDTH, default 4, opcode width; CNTWIDTH, default 16, stall-counter width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; all state is in the clk domain.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 opcodeD  input  OPCODEWIDTH  decode-stage opcode.
REQ-006 rs1D, rs2D  input  REGWIDTH each  decode-stage source registers.
REQ-007 rdD  input  REGWIDTH  decode-stage destination register.
REQ-008 writeEnableDD  input  1  decode instruction writes the register file.
REQ-009 resultSelectorWBD  input  1  1 = writeback from memory (load).
REQ-010 branchTakenE  input  1  branch in execute resolved taken this cycle.
REQ-011 stallF, stallD  output  1 each  hold fetch PC / decode register.
REQ-012 flushD, flushE  output  1 each  clear decode register / insert bubble into execute.
REQ-013 forwardAE, forwardBE  output  2 each  operand source: 00 regfile, 10 memory-stage ALU result, 01 writeback result.
REQ-014 stallCount  output  CNTWIDTH  count of load-use stall cycles.

Function
REQ-015 Internal shadow pipeline SHALL hold, per stage E/M/W: rd, writeEnable, isLoad (E only), plus rs1E, rs2E.
REQ-016 Each rising edge: W <= M; M <= E; E <= D fields, or bubble (writeEnable=0, isLoad=0, rd/rs=0) when flushE=1.
REQ-017 isLoad for E SHALL be writeEnableDD & resultSelectorWBD; stores and branches never count as hazard sources.
REQ-018 Load-use hazard (lwStall) SHALL be isLoadE & (rdE==rs1D | rdE==rs2D), combinational from current state and inputs.
REQ-019 lwStall=1 and branchTakenE=0: stallF=1, stallD=1, flushE=1, flushD=0; exactly one bubble per load-use pair.
REQ-020 branchTakenE=1: flushD=1, flushE=1, stallF=0, stallD=0, regardless of lwStall (branch wins).
REQ-021 Neither condition: stallF, stallD, flushD, flushE all 0.
REQ-022 forwardAE SHALL be 10 if writeEnableM & rdM==rs1E; else 01 if writeEnableW & rdW==rs1E; else 00; forwardBE identical using rs2E.
REQ-023 Memory stage SHALL take priority over writeback when both match.
REQ-024 Forwarding outputs SHALL depend only on registered state (no same-cycle D inputs).
REQ-025 stallCount SHALL increment by 1 on each rising edge where REQ-019 stall is asserted, saturating at all-ones.
REQ-026 Load followed by dependent: cycle n stall; n+1 bubble in E, load in M, no stall; n+2 dependent in E with forwardAE/BE=01.
REQ-027 Consecutive load-use stalls SHALL NOT occur for the same pair; a new load in E re-evaluates per REQ-018.

Reset
REQ-028 rst=0 SHALL immediately clear all shadow stages to bubble and stallCount to 0.
REQ-029 While rst=0 all outputs SHALL be 0 (flushes gated off, forward=00, stallCount=0).
REQ-030 First rising edge after rst deasserts SHALL capture decode inputs normally; reset mid-stall discards the pending stall.

Verification
REQ-031 Load rd=3 in E, D reads rs1=3 -> stallF=stallD=flushE=1 one cycle, stallCount 0->1; two cycles later forwardAE=01.
REQ-032 ALU write rd=5, next instruction reads rs2=5 -> next cycle forwardBE=10; one cycle later (with intervening non-writer) forwardBE=01.
REQ-033 M and W both write rd=2, E reads rs1=2 -> forwardAE=10.
REQ-034 branchTakenE=1 same cycle as lwStall -> flushD=flushE=1, stallF=stallD=0, stallCount unchanged.
REQ-035 Store (writeEnableDD=0) followed by reader of same rd -> no stall, forward=00.
REQ-036 Force stallCount to all-ones via repeated load-use pairs -> stays all-ones; assert rst=0 mid-stall -> all outputs 0 asynchronously.
